// File: rtl/magnitude_comparator_if.sv
// Operand/result bundle for the registered magnitude comparator.
// The master drives the two operands and watches the flag; the
// comparator itself sits on the slave side.
interface magnitude_comparator_if #(
    parameter int WIDTH = 10
);
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             result;

    modport master (
        output A,
        output B,
        input  result
    );

    modport slave (
        input  A,
        input  B,
        output result
    );
endinterface

// File: rtl/magnitude_comparator.sv
// Registered unsigned magnitude comparator: result goes high one edge
// after A is strictly greater than B.
// The computer player in tug-of-war feeds A with a zero-extended switch
// threshold and B with an LFSR value, so result acts as a random "press".
// Optional macro COMPARATOR_INPUT_REG_EN adds a register stage on both
// operands, making the total latency two edges; the ports do not change.
module magnitude_comparator #(
    parameter int WIDTH = 10
) (
    input  logic                   clk,
    input  logic                   reset,
    magnitude_comparator_if.slave  cmp_bus
);

    // Operands as seen by the compare cascade.
    logic [WIDTH-1:0] cmp_a;
    logic [WIDTH-1:0] cmp_b;

    // Per-bit greater/equal terms, kept as vectors so the cascade is easy to trace.
    logic [WIDTH-1:0] gt_bit;
    logic [WIDTH-1:0] eq_bit;

    // Running cascade state and the registered flag.
    logic gt_acc;
    logic eq_prefix;
    logic result_d;
    logic result_q;

`ifdef COMPARATOR_INPUT_REG_EN
    logic [WIDTH-1:0] a_d;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_d;
    logic [WIDTH-1:0] b_q;

    // Next value of the operand capture registers is simply the live bus.
    always_comb begin
        a_d = cmp_bus.A;
        b_d = cmp_bus.B;
    end

    // Operand capture stage; cleared on reset so the flag stays low two edges.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_q <= '0;
            b_q <= '0;
        end else begin
            a_q <= a_d;
            b_q <= b_d;
        end
    end

    assign cmp_a = a_q;
    assign cmp_b = b_q;
`else
    assign cmp_a = cmp_bus.A;
    assign cmp_b = cmp_bus.B;
`endif

    // Per-bit terms: A bit set where B bit is clear, and bitwise equality.
    always_comb begin
        gt_bit = cmp_a & ~cmp_b;
        eq_bit = ~(cmp_a ^ cmp_b);
    end

    // MSB-first cascade: a bit decides only if every higher bit was equal.
    always_comb begin
        gt_acc    = 1'b0;
        eq_prefix = 1'b1;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            gt_acc    = gt_acc | (eq_prefix & gt_bit[i]);
            eq_prefix = eq_prefix & eq_bit[i];
        end
        result_d = gt_acc;
    end

    // Output flag register; reset wins over any pending comparison.
    always_ff @(posedge clk) begin
        if (reset) begin
            result_q <= 1'b0;
        end else begin
            result_q <= result_d;
        end
    end

    assign cmp_bus.result = result_q;

endmodule

// File: tb/tb_magnitude_comparator.sv
// Self-checking bench for magnitude_comparator.
// A cycle model predicts the flag for every edge and pushes it into a
// scoreboard queue; it is popped and compared just after the edge.
// A vector table and a few hand-written sequences add direct checks.
module tb_magnitude_comparator;

    localparam int WIDTH = 10;
`ifdef COMPARATOR_INPUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             exp;
        string            name;
    } vec_t;

    logic clk;
    logic reset;

    magnitude_comparator_if #(.WIDTH(WIDTH)) cmp_bus ();

    magnitude_comparator #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .reset   (reset),
        .cmp_bus (cmp_bus.slave)
    );

    int   errors = 0;
    int   checks = 0;
    logic exp_q[$];

    // Bench-side model of the optional operand stage.
    logic [WIDTH-1:0] model_a = '0;
    logic [WIDTH-1:0] model_b = '0;

    vec_t vecs[11];

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run can never hang.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: time limit reached before summary");
        $fatal(1, "[TB] watchdog expired");
    end

    // Compare the live flag against a required value.
    task automatic check_output(input string name, input logic exp);
        checks++;
        if (cmp_bus.result !== exp) begin
            errors++;
            $display("[TB] FAIL %s: result=%b expected=%b at %0t", name, cmp_bus.result, exp, $time);
        end
    endtask

    // Drive one cycle of stimulus, predict the flag for the coming edge,
    // then after the edge pop the prediction and compare.
    task automatic apply_stimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                  input logic rst);
        logic exp;
        logic got_exp;
        cmp_bus.A = a;
        cmp_bus.B = b;
        reset     = rst;
`ifdef COMPARATOR_INPUT_REG_EN
        exp = rst ? 1'b0 : (model_a > model_b);
        model_a = rst ? '0 : a;
        model_b = rst ? '0 : b;
`else
        exp = rst ? 1'b0 : (a > b);
`endif
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("[TB] FAIL scoreboard: queue empty, result=%b", cmp_bus.result);
        end else begin
            got_exp = exp_q.pop_front();
            if (cmp_bus.result !== got_exp) begin
                errors++;
                $display("[TB] FAIL scoreboard: A=%0d B=%0d reset=%b result=%b expected=%b",
                         a, b, rst, cmp_bus.result, got_exp);
            end
        end
    endtask

    initial begin
        vecs[0]  = '{a: 10'd2,    b: 10'd128,  exp: 1'b0, name: "a_lt_b"};
        vecs[1]  = '{a: 10'd256,  b: 10'd128,  exp: 1'b1, name: "a_gt_b"};
        vecs[2]  = '{a: 10'd256,  b: 10'd256,  exp: 1'b0, name: "a_eq_b"};
        vecs[3]  = '{a: 10'd1023, b: 10'd1022, exp: 1'b1, name: "max_vs_max_m1"};
        vecs[4]  = '{a: 10'd0,    b: 10'd0,    exp: 1'b0, name: "zero_zero"};
        vecs[5]  = '{a: 10'd0,    b: 10'd1023, exp: 1'b0, name: "zero_vs_max"};
        vecs[6]  = '{a: 10'd1,    b: 10'd0,    exp: 1'b1, name: "one_vs_zero"};
        vecs[7]  = '{a: 10'd512,  b: 10'd511,  exp: 1'b1, name: "msb_vs_low"};
        vecs[8]  = '{a: 10'd511,  b: 10'd512,  exp: 1'b0, name: "low_vs_msb"};
        vecs[9]  = '{a: 10'd1023, b: 10'd0,    exp: 1'b1, name: "max_vs_zero"};
        vecs[10] = '{a: 10'd300,  b: 10'd5,    exp: 1'b1, name: "thr_vs_rand"};

        reset     = 1'b1;
        cmp_bus.A = '0;
        cmp_bus.B = '0;

        // Reset held two edges with A > B on the bus: flag must stay low.
        apply_stimulus(10'd300, 10'd5, 1'b1);
        check_output("reset_hold_1", 1'b0);
        apply_stimulus(10'd300, 10'd5, 1'b1);
        check_output("reset_hold_2", 1'b0);

        // Release: flag rises only after the configured latency.
        apply_stimulus(10'd300, 10'd5, 1'b0);
        check_output("release_edge1", (LAT == 1) ? 1'b1 : 1'b0);
        apply_stimulus(10'd300, 10'd5, 1'b0);
        check_output("release_edge2", 1'b1);

        // Table vectors: hold each for LAT edges, check, then one more steady edge.
        for (int v = 0; v < 11; v++) begin
            for (int k = 0; k < LAT; k++) begin
                apply_stimulus(vecs[v].a, vecs[v].b, 1'b0);
            end
            check_output(vecs[v].name, vecs[v].exp);
            apply_stimulus(vecs[v].a, vecs[v].b, 1'b0);
            check_output({vecs[v].name, "_hold"}, vecs[v].exp);
        end

        // Reset in mid-operation discards the pending comparison.
        apply_stimulus(10'd1023, 10'd0, 1'b0);
        apply_stimulus(10'd1023, 10'd0, 1'b1);
        check_output("mid_reset", 1'b0);
        apply_stimulus(10'd1023, 10'd0, 1'b0);
        check_output("mid_reset_rel1", (LAT == 1) ? 1'b1 : 1'b0);
        apply_stimulus(10'd0, 10'd0, 1'b0);
        check_output("mid_reset_rel2", (LAT == 1) ? 1'b0 : 1'b1);

        // Random operands with occasional reset pulses.
        for (int n = 0; n < 1000; n++) begin
            logic [WIDTH-1:0] ra;
            logic [WIDTH-1:0] rb;
            logic             rr;
            ra = WIDTH'($urandom_range(0, 1023));
            rb = WIDTH'($urandom_range(0, 1023));
            rr = ($urandom_range(0, 19) == 0);
            apply_stimulus(ra, rb, rr);
            if (rr) begin
                check_output("rand_reset", 1'b0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
